// File: rtl/card_game_ctrl.sv
// Card-match game controller: ROWS x COLS grid, LFSR shuffle, per-round time limit
// counted in video frames, and a timed face-up hold after a mismatched pair.
module card_game_ctrl #(
  parameter int          ROWS        = 4,
  parameter int          COLS        = 4,
  parameter int          FRAME_HZ    = 60,
  parameter int          TIME_LIMIT  = 120,
  parameter int          SHOW_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         N           = ROWS * COLS,
  localparam int         IDX_W       = $clog2(N),
  localparam int         FACE_W      = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  cmd_valid,
  input  logic [7:0]            cmd_code,
  output logic [1:0]            state,
  output logic                  busy,
  output logic [IDX_W-1:0]      cursor,
  output logic [N-1:0]          card_open,
  output logic [N-1:0]          card_found,
  output logic [N*FACE_W-1:0]   card_face,
  output logic [11:0]           left_time
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int FR_W   = (FRAME_HZ > 1) ? $clog2(FRAME_HZ) : 1;
  localparam int HOLD_W = $clog2(SHOW_FRAMES + 1);
  localparam int SH_W   = $clog2(4 * N);

  localparam logic [7:0] CMD_UP    = 8'h31;
  localparam logic [7:0] CMD_DOWN  = 8'h32;
  localparam logic [7:0] CMD_LEFT  = 8'h33;
  localparam logic [7:0] CMD_RIGHT = 8'h34;
  localparam logic [7:0] CMD_SEL   = 8'h35;
  localparam logic [7:0] CMD_ABORT = 8'h36;

  localparam logic [11:0]      TIME_INIT = 12'(TIME_LIMIT);
  localparam logic [IDX_W-1:0] COLS_I    = IDX_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

  // Encoding puts busy in bit 2 and the reported state in bits 1:0, so both
  // outputs come straight off the phase flops.
  typedef enum logic [2:0] {
    P_IDLE    = 3'b000,
    P_PLAY    = 3'b001,
    P_WIN     = 3'b010,
    P_LOSE    = 3'b011,
    P_SHUFFLE = 3'b100,
    P_HOLD    = 3'b101
  } phase_t;

  phase_t             phase;
  logic               vs_q;
  logic [15:0]        lfsr;
  logic [FACE_W-1:0]  face [N];
  logic [IDX_W-1:0]   swap_a, first_idx, second_idx;
  logic [SH_W-1:0]    shuf_cnt;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [FR_W-1:0]    frame_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               first_held, cmp_pend;

  logic               tick, in_game, frame_wrap, timeout;
  logic               faces_eq, win_now, sel_ok;
  logic               cmd_up, cmd_down, cmd_left, cmd_right, cmd_sel, cmd_abort;
  logic [IDX_W-1:0]   lfsr_b;
  logic [N-1:0]       pair_mask;

  assign state = phase[1:0];
  assign busy  = phase[2];

  assign cmd_up    = cmd_valid && (cmd_code == CMD_UP);
  assign cmd_down  = cmd_valid && (cmd_code == CMD_DOWN);
  assign cmd_left  = cmd_valid && (cmd_code == CMD_LEFT);
  assign cmd_right = cmd_valid && (cmd_code == CMD_RIGHT);
  assign cmd_sel   = cmd_valid && (cmd_code == CMD_SEL);
  assign cmd_abort = cmd_valid && (cmd_code == CMD_ABORT);

  assign tick       = vs_in & ~vs_q;
  assign lfsr_b     = lfsr[IDX_W-1:0];
  assign in_game    = (phase == P_PLAY) || (phase == P_HOLD);
  assign frame_wrap = tick && (frame_cnt == FR_W'(FRAME_HZ - 1));
  assign timeout    = in_game && frame_wrap && (left_time == 12'd1);
  assign pair_mask  = (N'(1) << first_idx) | (N'(1) << second_idx);
  assign faces_eq   = (face[first_idx] == face[second_idx]);
  assign win_now    = cmp_pend && faces_eq && (&(card_found | pair_mask));
  assign sel_ok     = (phase == P_PLAY) && !cmp_pend && cmd_sel &&
                      !card_open[cursor] && !card_found[cursor];

  // NOTE: every bit of a combinational output gets a default before the loop
  // fills it in, so no path through the block can leave it unassigned (latch).
  always_comb begin
    card_face = '0;
    for (int i = 0; i < N; i++) card_face[i*FACE_W +: FACE_W] = face[i];
  end

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in this block deliberately override earlier ones (abort last).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= P_IDLE;
      vs_q       <= 1'b0;
      lfsr       <= LFSR_SEED;
      cursor     <= '0;
      row        <= '0;
      col        <= '0;
      card_open  <= '0;
      card_found <= '0;
      left_time  <= TIME_INIT;
      // NOTE: the face table is reset on purpose: the display needs a defined
      // identity layout before the first shuffle, so it is a small register
      // file rather than a RAM.
      for (int i = 0; i < N; i++) face[i] <= FACE_W'(i >> 1);
      swap_a     <= '0;
      shuf_cnt   <= '0;
      first_idx  <= '0;
      second_idx <= '0;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      first_held <= 1'b0;
      cmp_pend   <= 1'b0;
    end else begin
      vs_q <= vs_in;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      case (phase)
        P_IDLE, P_WIN, P_LOSE: begin
          if (cmd_sel) begin
            phase <= P_SHUFFLE;
            for (int i = 0; i < N; i++) face[i] <= FACE_W'(i >> 1);
            swap_a     <= '0;
            shuf_cnt   <= '0;
            first_held <= 1'b0;
            cmp_pend   <= 1'b0;
          end
        end

        P_SHUFFLE: begin
          // Out-of-range LFSR draws (non power-of-two grids) are simply skipped.
          if (int'(lfsr_b) < N) begin
            face[swap_a] <= face[lfsr_b];
            face[lfsr_b] <= face[swap_a];
          end
          swap_a   <= (swap_a == IDX_W'(N - 1)) ? '0 : swap_a + IDX_W'(1);
          shuf_cnt <= shuf_cnt + SH_W'(1);
          if (shuf_cnt == SH_W'(4 * N - 1)) begin
            phase      <= P_PLAY;
            cursor     <= '0;
            row        <= '0;
            col        <= '0;
            card_open  <= '0;
            card_found <= '0;
            left_time  <= TIME_INIT;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
          end
        end

        P_PLAY, P_HOLD: begin
          if (cmd_up && row != '0) begin
            row    <= row - ROW_W'(1);
            cursor <= cursor - COLS_I;
          end else if (cmd_down && row != ROW_LAST) begin
            row    <= row + ROW_W'(1);
            cursor <= cursor + COLS_I;
          end else if (cmd_left && col != '0) begin
            col    <= col - COL_W'(1);
            cursor <= cursor - IDX_W'(1);
          end else if (cmd_right && col != COL_LAST) begin
            col    <= col + COL_W'(1);
            cursor <= cursor + IDX_W'(1);
          end

          if (tick) frame_cnt <= frame_wrap ? '0 : frame_cnt + FR_W'(1);
          if (frame_wrap) left_time <= left_time - 12'd1;

          // Completing the board outranks a coincident timeout.
          if (win_now) begin
            card_found <= card_found | pair_mask;
            card_open  <= card_open & ~pair_mask;
            first_held <= 1'b0;
            cmp_pend   <= 1'b0;
            phase      <= P_WIN;
          end else if (timeout) begin
            cmp_pend <= 1'b0;
            phase    <= P_LOSE;
          end else if (cmp_pend) begin
            cmp_pend <= 1'b0;
            if (faces_eq) begin
              card_found <= card_found | pair_mask;
              card_open  <= card_open & ~pair_mask;
              first_held <= 1'b0;
            end else begin
              hold_cnt <= '0;
              phase    <= P_HOLD;
            end
          end else if (phase == P_HOLD) begin
            if (tick) begin
              if (hold_cnt == HOLD_W'(SHOW_FRAMES - 1)) begin
                card_open  <= card_open & ~pair_mask;
                first_held <= 1'b0;
                phase      <= P_PLAY;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end else if (sel_ok) begin
            card_open[cursor] <= 1'b1;
            if (!first_held) begin
              first_held <= 1'b1;
              first_idx  <= cursor;
            end else begin
              second_idx <= cursor;
              cmp_pend   <= 1'b1;
            end
          end
        end

        default: phase <= P_IDLE;
      endcase

      if (cmd_abort && phase != P_SHUFFLE) begin
        phase      <= P_IDLE;
        card_open  <= '0;
        card_found <= '0;
        left_time  <= TIME_INIT;
        first_held <= 1'b0;
        cmp_pend   <= 1'b0;
        frame_cnt  <= '0;
        hold_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_card_game_ctrl.sv
// Directed bench for card_game_ctrl: a default 4x4 instance plus a short-timer
// instance (TIME_LIMIT=2, FRAME_HZ=4); shuffles are predicted from an LFSR model.
module tb_card_game_ctrl;

  localparam logic [7:0] K_UP    = 8'h31;
  localparam logic [7:0] K_DOWN  = 8'h32;
  localparam logic [7:0] K_LEFT  = 8'h33;
  localparam logic [7:0] K_RIGHT = 8'h34;
  localparam logic [7:0] K_SEL   = 8'h35;
  localparam logic [7:0] K_ABORT = 8'h36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        vs_m = 1'b0, cv_m = 1'b0;
  logic [7:0]  cc_m = 8'h00;
  logic [1:0]  st_m;
  logic        busy_m;
  logic [3:0]  cur_m;
  logic [15:0] open_m, found_m;
  logic [47:0] face_m;
  logic [11:0] lt_m;

  logic        vs_t = 1'b0, cv_t = 1'b0;
  logic [7:0]  cc_t = 8'h00;
  logic [1:0]  st_t;
  logic        busy_t;
  logic [3:0]  cur_t;
  logic [15:0] open_t, found_t;
  logic [47:0] face_t;
  logic [11:0] lt_t;

  int checks = 0;
  int errors = 0;
  int cur [2];
  int exp_face [2][16];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  card_game_ctrl dut_m (
    .clk(clk), .rst(rst), .vs_in(vs_m), .cmd_valid(cv_m), .cmd_code(cc_m),
    .state(st_m), .busy(busy_m), .cursor(cur_m), .card_open(open_m),
    .card_found(found_m), .card_face(face_m), .left_time(lt_m)
  );

  card_game_ctrl #(.TIME_LIMIT(2), .FRAME_HZ(4)) dut_t (
    .clk(clk), .rst(rst), .vs_in(vs_t), .cmd_valid(cv_t), .cmd_code(cc_t),
    .state(st_t), .busy(busy_t), .cursor(cur_t), .card_open(open_t),
    .card_found(found_t), .card_face(face_t), .left_time(lt_t)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int which, input logic [7:0] code);
    @(negedge clk);
    if (which == 0) begin cv_m = 1'b1; cc_m = code; end
    else            begin cv_t = 1'b1; cc_t = code; end
    @(negedge clk);
    cv_m = 1'b0;
    cv_t = 1'b0;
  endtask

  task automatic pulse_vs(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (which == 0) vs_m = 1'b1; else vs_t = 1'b1;
      @(negedge clk);
      vs_m = 1'b0;
      vs_t = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_shuffle(input int which, input logic [15:0] l0);
    logic [15:0] l;
    int a, b, t;
    l = l0;
    for (int i = 0; i < 16; i++) exp_face[which][i] = i >> 1;
    for (int k = 0; k < 64; k++) begin
      a = k % 16;
      b = int'(l[3:0]);
      t = exp_face[which][a];
      exp_face[which][a] = exp_face[which][b];
      exp_face[which][b] = t;
      l = lfsr_next(l);
    end
  endtask

  function automatic logic [47:0] face_vec(input int which);
    logic [47:0] v;
    for (int i = 0; i < 16; i++) v[i*3 +: 3] = 3'(exp_face[which][i]);
    return v;
  endfunction

  task automatic start_game(input int which);
    int cnt;
    int ok;
    int seen;
    logic [47:0] fv;
    send(which, K_SEL);
    model_shuffle(which, m_lfsr);
    cnt = 0;
    while ((which == 0 ? busy_m : busy_t) && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("shuffle_busy_cycles", 64'(cnt), 64'd64);
    check("shuffle_state", which == 0 ? st_m : st_t, 64'd1);
    check("shuffle_faces", which == 0 ? face_m : face_t, face_vec(which));
    fv = (which == 0) ? face_m : face_t;
    ok = 1;
    for (int id = 0; id < 8; id++) begin
      seen = 0;
      for (int i = 0; i < 16; i++) if (int'(fv[i*3 +: 3]) == id) seen++;
      if (seen != 2) ok = 0;
    end
    check("shuffle_perm", 64'(ok), 64'd1);
    cur[which] = 0;
  endtask

  task automatic goto(input int which, input int target);
    while (cur[which] / 4 > target / 4) begin send(which, K_UP);    cur[which] -= 4; end
    while (cur[which] / 4 < target / 4) begin send(which, K_DOWN);  cur[which] += 4; end
    while (cur[which] % 4 > target % 4) begin send(which, K_LEFT);  cur[which] -= 1; end
    while (cur[which] % 4 < target % 4) begin send(which, K_RIGHT); cur[which] += 1; end
    check("goto_cursor", which == 0 ? cur_m : cur_t, 64'(target));
  endtask

  task automatic find_pair(input int which, input int f, output int a, output int b);
    a = -1;
    b = -1;
    for (int i = 0; i < 16; i++)
      if (exp_face[which][i] == f) begin
        if (a < 0) a = i; else if (b < 0) b = i;
      end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, q, r, a, b;
    logic [15:0] fmask, pmask;
    logic [47:0] ident;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) ident[i*3 +: 3] = 3'(i >> 1);
    check("rst_state", st_m, 64'd0);
    check("rst_busy", busy_m, 64'd0);
    check("rst_cursor", cur_m, 64'd0);
    check("rst_open", open_m, 64'd0);
    check("rst_found", found_m, 64'd0);
    check("rst_left_time", lt_m, 64'd120);
    check("rst_faces", face_m, ident);

    start_game(0);
    check("play_left_time", lt_m, 64'd120);

    send(0, K_UP);    check("cur_up_edge", cur_m, 64'd0);
    send(0, K_LEFT);  check("cur_left_edge", cur_m, 64'd0);
    repeat (8) send(0, K_RIGHT);
    check("cur_right_x8", cur_m, 64'd3);
    send(0, K_DOWN);  check("cur_down", cur_m, 64'd7);
    send(0, K_DOWN);
    send(0, K_DOWN);  check("cur_down_x2", cur_m, 64'd15);
    send(0, K_DOWN);  check("cur_down_edge", cur_m, 64'd15);
    send(0, K_RIGHT); check("cur_right_edge", cur_m, 64'd15);
    cur[0] = 15;

    // Matching pair starting at card 0.
    find_pair(0, exp_face[0][0], a, b);
    goto(0, a);
    send(0, K_SEL);
    check("match_first_open", open_m, 64'(16'(1) << a));
    goto(0, b);
    send(0, K_SEL);
    pmask = (16'(1) << a) | (16'(1) << b);
    check("match_both_open", open_m, 64'(pmask));
    @(negedge clk);
    check("match_found", found_m, 64'(pmask));
    check("match_open_clear", open_m, 64'd0);
    check("match_busy", busy_m, 64'd0);
    fmask = pmask;

    // Mismatched pair, then the reveal hold.
    p = -1; q = -1; r = -1;
    for (int i = 0; i < 16; i++) if (!fmask[i] && p < 0) p = i;
    for (int i = 0; i < 16; i++)
      if (!fmask[i] && q < 0 && exp_face[0][i] != exp_face[0][p]) q = i;
    for (int i = 0; i < 16; i++) if (!fmask[i] && r < 0 && i != p && i != q) r = i;
    pmask = (16'(1) << p) | (16'(1) << q);
    goto(0, p);
    send(0, K_SEL);
    goto(0, q);
    send(0, K_SEL);
    @(negedge clk);
    check("miss_open", open_m, 64'(pmask));
    check("miss_busy", busy_m, 64'd1);
    check("miss_state", st_m, 64'd1);
    goto(0, r);
    send(0, K_SEL);
    check("hold_sel_ignored", open_m, 64'(pmask));
    pulse_vs(0, 29);
    check("hold_busy_29", busy_m, 64'd1);
    check("hold_open_29", open_m, 64'(pmask));
    pulse_vs(0, 1);
    check("hold_busy_30", busy_m, 64'd0);
    check("hold_open_30", open_m, 64'd0);
    check("hold_found_kept", found_m, 64'(fmask));
    check("hold_left_time", lt_m, 64'd120);

    send(0, K_ABORT);
    check("abort_state", st_m, 64'd0);
    check("abort_open", open_m, 64'd0);
    check("abort_found", found_m, 64'd0);
    check("abort_left_time", lt_m, 64'd120);
    check("abort_faces_kept", face_m, face_vec(0));

    // Short-timer instance: timeout, reshuffle, then a win racing the last tick.
    start_game(1);
    check("t_left_init", lt_t, 64'd2);
    pulse_vs(1, 4);
    check("t_left_after4", lt_t, 64'd1);
    check("t_state_after4", st_t, 64'd1);
    pulse_vs(1, 4);
    check("t_left_after8", lt_t, 64'd0);
    check("t_state_lose", st_t, 64'd3);

    start_game(1);
    check("t_reshuffle_left", lt_t, 64'd2);
    check("t_reshuffle_found", found_t, 64'd0);
    pulse_vs(1, 7);
    check("t_left_after7", lt_t, 64'd1);

    fmask = '0;
    for (int f = 0; f < 7; f++) begin
      find_pair(1, f, a, b);
      goto(1, a);
      send(1, K_SEL);
      goto(1, b);
      send(1, K_SEL);
      @(negedge clk);
      fmask = fmask | (16'(1) << a) | (16'(1) << b);
    end
    check("t_found_7pairs", found_t, 64'(fmask));
    check("t_state_7pairs", st_t, 64'd1);

    find_pair(1, 7, a, b);
    goto(1, a);
    send(1, K_SEL);
    goto(1, b);
    @(negedge clk);
    cv_t = 1'b1;
    cc_t = K_SEL;
    @(negedge clk);
    cv_t = 1'b0;
    vs_t = 1'b1;
    @(negedge clk);
    vs_t = 1'b0;
    check("t_win_vs_timeout", st_t, 64'd2);
    check("t_win_found", found_t, 64'hFFFF);
    pulse_vs(1, 1);
    check("t_win_held", st_t, 64'd2);
    send(1, K_ABORT);
    check("t_abort_state", st_t, 64'd0);
    check("t_abort_left", lt_t, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
